vedic_mult8_pipe: RTL and testbench

Pipelined 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier. It consumes operand pairs from an upstream valid/ready source and forms four 4x4 partial products. It reduces them through carry-lookahead additions over two further register stages and delivers a 16-bit product downstream. It is the stage that feeds the team's carry-lookahead adder slices, with a delivered-product counter for throughput monitoring.

---
 rtl/vedic_pkg.sv | 61 ++++++
 rtl/vedic_mult4.sv | 25 ++
 rtl/vedic_mult8_pipe.sv | 61 ++++++
 tb/tb_vedic_mult8_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared widths, pipeline stage records and carry-lookahead helpers for the
// 8x8 Vedic multiplier.
package vedic_pkg;
  localparam int OPW   = 8;
  localparam int HALF  = 4;
  localparam int PRODW = 16;
  localparam int MIDW  = 9;

  typedef struct packed {
    logic            v;
    logic [OPW-1:0]  ll;
    logic [OPW-1:0]  lh;
    logic [OPW-1:0]  hl;
    logic [OPW-1:0]  hh;
  } s1_t;

  typedef struct packed {
    logic            v;
    logic [MIDW-1:0] mid;
    logic [OPW-1:0]  ll;
    logic [OPW-1:0]  hh;
  } s2_t;

  typedef struct packed {
    logic             v;
    logic [PRODW-1:0] prod;
  } s3_t;

  // 4-bit carry-lookahead slice: returns {cout, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // 16-bit sum from four chained slices; the final carry is dropped since
  // the product never overflows 16 bits.
  function automatic logic [PRODW-1:0] cla16(input logic [PRODW-1:0] x,
                                             input logic [PRODW-1:0] y);
    logic [4:0]       s;
    logic             c;
    logic [PRODW-1:0] sum;
    c   = 1'b0;
    sum = '0;
    for (int k = 0; k < PRODW/4; k++) begin
      s            = cla4(x[4*k +: 4], y[4*k +: 4], c);
      sum[4*k +: 4] = s[3:0];
      c            = s[4];
    end
    return sum;
  endfunction
endpackage

// File: rtl/vedic_mult4.sv
// 4x4 combinational Urdhva-Tiryagbhyam multiplier: column-wise vertical and
// crosswise bit products with the column carry rippled into the next column.
module vedic_mult4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [2:0] col;
  logic [2:0] carry;

  always_comb begin
    col   = '0;
    carry = '0;
    p     = '0;
    for (int k = 0; k < 7; k++) begin
      col = carry;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (i + j == k) col = col + {2'b00, a[i] & b[j]};
      p[k]  = col[0];
      carry = {1'b0, col[2:1]};
    end
    p[7] = carry[0];
  end
endmodule

// File: rtl/vedic_mult8_pipe.sv
// 3-stage pipelined 8x8 Vedic multiplier with valid/ready flow control and a
// delivered-product counter.
module vedic_mult8_pipe
  import vedic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PRODW-1:0] prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] prod_cnt
);
  logic [3:0][OPW-1:0] pp;
  logic [3:1]          rdy;
  logic [4:0]          mid_lo, mid_hi;
  logic [PRODW-1:0]    prod_nxt;
  s1_t                 s1;
  s2_t                 s2;
  s3_t                 s3;

  // pp index = {b half, a half}: 0=ll, 1=hl, 2=lh, 3=hh
  for (genvar g = 0; g < 4; g++) begin : g_pp
    vedic_mult4 u_m4 (
      .a (a[HALF*(g%2) +: HALF]),
      .b (b[HALF*(g/2) +: HALF]),
      .p (pp[g])
    );
  end

  assign rdy[3]   = !s3.v || out_ready;
  assign rdy[2]   = !s2.v || rdy[3];
  assign rdy[1]   = !s1.v || rdy[2];
  assign in_ready = rdy[1] || rst;

  assign mid_lo   = cla4(s1.lh[3:0], s1.hl[3:0], 1'b0);
  assign mid_hi   = cla4(s1.lh[7:4], s1.hl[7:4], mid_lo[4]);
  assign prod_nxt = cla16({s2.hh, s2.ll}, {3'b000, s2.mid, 4'b0000});

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      prod_cnt <= '0;
    end else begin
      if (rdy[1]) s1 <= '{v: in_valid, ll: pp[0], lh: pp[2], hl: pp[1], hh: pp[3]};
      if (rdy[2]) s2 <= '{v: s1.v, mid: {mid_hi, mid_lo[3:0]}, ll: s1.ll, hh: s1.hh};
      if (rdy[3]) s3 <= '{v: s2.v, prod: prod_nxt};
      if (s3.v && out_ready) prod_cnt <= prod_cnt + 1'b1;
    end
  end

  assign prod      = s3.prod;
  assign out_valid = s3.v;
endmodule

// File: tb/tb_vedic_mult8_pipe.sv
// Directed table, flow-control sequences and random stream against a queue
// scoreboard for vedic_mult8_pipe.
module tb_vedic_mult8_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid;
  logic [15:0] prod, prod_cnt;
  logic        in_ready2, out_valid2;
  logic [15:0] prod2;
  logic [1:0]  cnt2;

  vedic_mult8_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .prod_cnt(prod_cnt));

  vedic_mult8_pipe #(.CNT_W(2)) u_w2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready2),
    .prod(prod2), .out_valid(out_valid2), .out_ready(out_ready), .prod_cnt(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [15:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_prod = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: order, values, counter and hold-under-backpressure
  always @(posedge clk) begin
    if (!rst && hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_prod", prod, hold_prod);
    end
    hold_pend = !rst && out_valid && !out_ready;
    hold_prod = prod;
    if (rst) begin
      exp_q.delete();
      n_out = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got %0h expected no output", prod);
        end else chk("sb_prod", prod, exp_q.pop_front());
        chk("sb_cnt", prod_cnt, n_out[15:0]);
        chk("sb_cnt2", cnt2, n_out[1:0]);
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(16'(a) * 16'(b));
    end
  end

  vec_t tbl[10];
  vec_t strm[3];
  vec_t bp[5];
  int   wrap_exp[5];

  initial begin
    int   idx, n0, seen;
    logic acc;

    tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[1] = '{8'hA5, 8'h3C, 16'h26AC};
    tbl[2] = '{8'h00, 8'h7F, 16'h0000};
    tbl[3] = '{8'h10, 8'h10, 16'h0100};
    tbl[4] = '{8'h0F, 8'h0F, 16'h00E1};
    tbl[5] = '{8'h80, 8'h02, 16'h0100};
    tbl[6] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[7] = '{8'h12, 8'h34, 16'h03A8};
    tbl[8] = '{8'hF0, 8'h0F, 16'h0E10};
    tbl[9] = '{8'hAA, 8'h55, 16'h3872};
    strm[0] = '{8'hA5, 8'h3C, 16'h26AC};
    strm[1] = '{8'h00, 8'h7F, 16'h0000};
    strm[2] = '{8'h10, 8'h10, 16'h0100};
    bp[0] = '{8'h11, 8'h11, 16'h0121};
    bp[1] = '{8'h22, 8'h03, 16'h0066};
    bp[2] = '{8'hFE, 8'hFE, 16'hFC04};
    bp[3] = '{8'h07, 8'h09, 16'h003F};
    bp[4] = '{8'h80, 8'h80, 16'h4000};
    wrap_exp = '{1, 2, 3, 0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_cnt", prod_cnt, 0);
    chk("rst_cnt2", cnt2, 0);

    // single ops: visible after accept edge + 2, handed off on the next edge
    for (int i = 0; i < 10; i++) begin
      a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("vec_lat1", out_valid, 0);
      @(posedge clk); #1;
      chk("vec_lat2", out_valid, 0);
      @(posedge clk); #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_prod", prod, tbl[i].p);
      @(posedge clk); #1;
      chk("vec_gone", out_valid, 0);
      chk("vec_cnt", prod_cnt, i + 1);
    end

    // back-to-back stream
    for (int i = 0; i < 3; i++) begin
      a = strm[i].a; b = strm[i].b; in_valid = 1'b1;
      #1 chk("strm_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("strm_valid", out_valid, 1);
      chk("strm_prod", prod, strm[i].p);
      @(posedge clk); #1;
    end
    chk("strm_done", out_valid, 0);

    // backpressure: three accepted, then stall
    out_ready = 1'b0;
    idx = 0;
    n0 = n_out;
    for (int c = 0; c < 6; c++) begin
      if (idx < 5) begin a = bp[idx].a; b = bp[idx].b; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1 acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    #1;
    chk("bp_accepts", idx, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_prod", prod, bp[0].p);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      a = bp[idx].a; b = bp[idx].b; in_valid = 1'b1;
      #1 acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_in", idx, 5);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_outs", n_out - n0, 5);

    // reset with two ops in flight
    for (int i = 0; i < 2; i++) begin
      a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("mrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_prod", prod, 0);
    chk("mrst_cnt", prod_cnt, 0);
    chk("mrst_cnt2", cnt2, 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mrst_no_stale", seen, 0);

    // 2-bit counter wrap
    for (int i = 0; i < 5; i++) begin
      a = 8'h03; b = 8'h05; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("wrap_cnt2", cnt2, wrap_exp[i]);
      chk("wrap_cnt16", prod_cnt, i + 1);
    end

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      a = 8'($urandom); b = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
